// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and enums for the PWM compare loader
package pwm_pkg;
  localparam int PWM_WIDTH = 18;
  localparam int PWM_FRAC  = 6;
  localparam int PWM_NCH   = 2;

  typedef enum logic {
    SEL_H = 1'b0,
    SEL_L = 1'b1
  } cmp_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ldr_state_t;
endpackage

// File: rtl/pwm_dither_acc.sv
// rtl/pwm_dither_acc.sv - per-channel fractional phase accumulator; adds its carry to the falling compare
module pwm_dither_acc
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int FRAC  = PWM_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tb_zero,
  input  logic [WIDTH-1:0] cmp_int,
  input  logic [FRAC-1:0]  cmp_frac,
  output logic [WIDTH-1:0] cmp_out
);
  logic [FRAC-1:0] acc_q;
  logic            carry_q;
  logic [FRAC:0]   sum;
  logic [WIDTH:0]  dith;

  assign sum = {1'b0, acc_q} + {1'b0, cmp_frac};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (tb_zero) begin
      acc_q   <= sum[FRAC-1:0];
      carry_q <= sum[FRAC];
    end
  end

  // carry applies to the whole period; clamp instead of wrapping to zero
  assign dith    = {1'b0, cmp_int} + {{WIDTH{1'b0}}, carry_q};
  assign cmp_out = dith[WIDTH] ? {WIDTH{1'b1}} : dith[WIDTH-1:0];
endmodule

// File: rtl/pwm_cmp_loader.sv
// rtl/pwm_cmp_loader.sv - double-buffered PWM compare loader, transfer on timebase zero
// Optional fractional dither of cmpL enabled by `define PWM_CMP_DITHER_EN.
module pwm_cmp_loader
  import pwm_pkg::*;
#(
  parameter int NCH   = PWM_NCH,
  parameter int WIDTH = PWM_WIDTH,
  parameter int FRAC  = PWM_FRAC,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [CW-1:0]         wr_chan,
  input  logic                  wr_sel,
  input  logic [WIDTH+FRAC-1:0] wr_data,
  input  logic                  commit,
  input  logic                  tb_zero,
  output logic                  pending,
  output logic [NCH*WIDTH-1:0]  cmpH_o,
  output logic [NCH*WIDTH-1:0]  cmpL_o
);
`ifdef PWM_CMP_DITHER_EN
  localparam int SLW = WIDTH + FRAC;
`else
  localparam int SLW = WIDTH;
  logic unused_frac;
  assign unused_frac = ^wr_data[FRAC-1:0];
`endif

  ldr_state_t       state_q, state_d;
  logic             xfer;
  logic             wr_fire;
  logic [WIDTH-1:0] sh_h  [NCH];
  logic [SLW-1:0]   sh_l  [NCH];
  logic [WIDTH-1:0] act_h [NCH];
  logic [WIDTH-1:0] act_l [NCH];
`ifdef PWM_CMP_DITHER_EN
  logic [FRAC-1:0]  act_f [NCH];
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE:  if (commit) state_d = ARMED;
      ARMED: if (tb_zero) begin
        xfer    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending  = (state_q == ARMED);
  assign wr_ready = ~pending;
  // out-of-range channels are handshaken but never land anywhere
  assign wr_fire  = wr_valid && wr_ready && (int'(wr_chan) < NCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        sh_h[c] <= '0;
        sh_l[c] <= '0;
      end
    end else if (wr_fire) begin
      if (cmp_sel_t'(wr_sel) == SEL_H) sh_h[wr_chan] <= wr_data[WIDTH+FRAC-1:FRAC];
      else                             sh_l[wr_chan] <= wr_data[WIDTH+FRAC-1 -: SLW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        act_h[c] <= '0;
        act_l[c] <= '0;
`ifdef PWM_CMP_DITHER_EN
        act_f[c] <= '0;
`endif
      end
    end else if (xfer) begin
      for (int c = 0; c < NCH; c++) begin
        act_h[c] <= sh_h[c];
        act_l[c] <= sh_l[c][SLW-1 -: WIDTH];
`ifdef PWM_CMP_DITHER_EN
        act_f[c] <= sh_l[c][FRAC-1:0];
`endif
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign cmpH_o[c*WIDTH +: WIDTH] = act_h[c];
`ifdef PWM_CMP_DITHER_EN
    pwm_dither_acc #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_dither (
      .clk      (clk),
      .rst      (rst),
      .tb_zero  (tb_zero),
      .cmp_int  (act_l[c]),
      .cmp_frac (act_f[c]),
      .cmp_out  (cmpL_o[c*WIDTH +: WIDTH])
    );
`else
    assign cmpL_o[c*WIDTH +: WIDTH] = act_l[c];
`endif
  end
endmodule

// File: tb/tb_pwm_cmp_loader.sv
// tb/tb_pwm_cmp_loader.sv - directed self-checking bench for pwm_cmp_loader
module tb_pwm_cmp_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_chan;
  logic        wr_sel;
  logic [23:0] wr_data;
  logic        commit;
  logic        tb_zero;
  logic        pending;
  logic [35:0] cmpH_o;
  logic [35:0] cmpL_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_cmp_loader dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_chan  (wr_chan),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .commit   (commit),
    .tb_zero  (tb_zero),
    .pending  (pending),
    .cmpH_o   (cmpH_o),
    .cmpL_o   (cmpL_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic ch, input logic sel, input logic [17:0] ival, input logic [5:0] fval);
    wr_valid = 1'b1;
    wr_chan  = ch;
    wr_sel   = sel;
    wr_data  = {ival, fval};
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic do_zero();
    tb_zero = 1'b1;
    step();
    tb_zero = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_chan = '0; wr_sel = 1'b0; wr_data = '0;
    commit = 1'b0; tb_zero = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (cmpH_o !== 36'h0) begin errors++; $display("FAIL reset_cmpH got %h exp 0", cmpH_o); end
    checks++; if (cmpL_o !== 36'h0) begin errors++; $display("FAIL reset_cmpL got %h exp 0", cmpL_o); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", pending); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
  endtask

  task automatic test_load_latency();
    int bad = 0;
    do_write(1'b1, 1'b0, 18'h20000, 6'h15);
    do_write(1'b1, 1'b1, 18'h0D709, 6'h00);
    checks++; if (cmpH_o !== 36'h0 || cmpL_o !== 36'h0) begin
      errors++; $display("FAIL write_no_effect got H=%h L=%h exp 0", cmpH_o, cmpL_o);
    end
    do_commit();
    checks++; if (pending !== 1'b1 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL commit_arm got pending=%b ready=%b exp 1/0", pending, wr_ready);
    end
    for (int i = 0; i < 36; i++) begin
      step();
      if (cmpH_o !== 36'h0 || cmpL_o !== 36'h0 || pending !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_37 got %0d bad cycles exp 0", bad); end
    do_zero();
    checks++; if (cmpH_o !== {18'h20000, 18'h0}) begin
      errors++; $display("FAIL xfer_cmpH got %h exp %h", cmpH_o, {18'h20000, 18'h0});
    end
    checks++; if (cmpL_o !== {18'h0D709, 18'h0}) begin
      errors++; $display("FAIL xfer_cmpL got %h exp %h", cmpL_o, {18'h0D709, 18'h0});
    end
    checks++; if (pending !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL xfer_pending got pending=%b ready=%b exp 0/1", pending, wr_ready);
    end
  endtask

  task automatic test_commit_coincident();
    do_write(1'b1, 1'b0, 18'h00500, 6'h00);
    commit = 1'b1; tb_zero = 1'b1;
    step();
    commit = 1'b0; tb_zero = 1'b0;
    checks++; if (pending !== 1'b1 || cmpH_o[35:18] !== 18'h20000) begin
      errors++; $display("FAIL coinc_no_xfer got pending=%b ch1H=%h exp 1/20000", pending, cmpH_o[35:18]);
    end
    repeat (5) step();
    do_zero();
    checks++; if (pending !== 1'b0 || cmpH_o[35:18] !== 18'h00500) begin
      errors++; $display("FAIL coinc_next_xfer got pending=%b ch1H=%h exp 0/00500", pending, cmpH_o[35:18]);
    end
  endtask

  task automatic test_locked_write();
    do_commit();
    wr_valid = 1'b1; wr_chan = 1'b0; wr_sel = 1'b1; wr_data = {18'h12345, 6'h00};
    step();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL locked_ready got %b exp 0", wr_ready); end
    repeat (3) step();
    tb_zero = 1'b1;
    step();
    tb_zero = 1'b0;
    checks++; if (cmpL_o[17:0] !== 18'h0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL locked_shadow got ch0L=%h ready=%b exp 0/1", cmpL_o[17:0], wr_ready);
    end
    step();
    wr_valid = 1'b0;
    do_commit();
    do_zero();
    checks++; if (cmpL_o[17:0] !== 18'h12345 || cmpH_o[35:18] !== 18'h00500) begin
      errors++; $display("FAIL late_write got ch0L=%h ch1H=%h exp 12345/00500", cmpL_o[17:0], cmpH_o[35:18]);
    end
  endtask

  task automatic test_dither();
    int hits = 0;
    int bad = 0;
    int exp_hits;
`ifdef PWM_CMP_DITHER_EN
    exp_hits = 2;
`else
    exp_hits = 0;
`endif
    do_write(1'b0, 1'b1, 18'h00100, 6'h10);
    do_commit();
    do_zero();
    checks++; if (cmpL_o[17:0] !== 18'h00100) begin
      errors++; $display("FAIL dither_load got %h exp 00100", cmpL_o[17:0]);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (3) step();
      do_zero();
      if (cmpL_o[17:0] === 18'h00101) hits++;
      else if (cmpL_o[17:0] !== 18'h00100) bad++;
    end
    checks++; if (hits != exp_hits || bad != 0) begin
      errors++; $display("FAIL dither_count got hits=%0d bad=%0d exp hits=%0d bad=0", hits, bad, exp_hits);
    end
    do_write(1'b0, 1'b1, 18'h3FFFF, 6'h3F);
    do_commit();
    do_zero();
    bad = 0;
    if (cmpL_o[17:0] !== 18'h3FFFF) bad++;
    for (int i = 0; i < 4; i++) begin
      repeat (2) step();
      do_zero();
      if (cmpL_o[17:0] !== 18'h3FFFF) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL dither_sat got %0d bad periods last=%h exp 0 / 3ffff", bad, cmpL_o[17:0]);
    end
  endtask

  task automatic test_reset_armed();
    do_write(1'b0, 1'b0, 18'h0ABCD, 6'h00);
    do_commit();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rst_arm got %b exp 1", pending); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pending !== 1'b0 || cmpH_o !== 36'h0 || cmpL_o !== 36'h0) begin
      errors++; $display("FAIL rst_clear got pending=%b H=%h L=%h exp 0", pending, cmpH_o, cmpL_o);
    end
    do_zero();
    checks++; if (pending !== 1'b0 || cmpH_o !== 36'h0 || cmpL_o !== 36'h0) begin
      errors++; $display("FAIL rst_no_xfer got pending=%b H=%h L=%h exp 0", pending, cmpH_o, cmpL_o);
    end
    do_commit();
    do_zero();
    checks++; if (cmpH_o !== 36'h0) begin
      errors++; $display("FAIL rst_shadow got H=%h exp 0", cmpH_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_commit_coincident();
    test_locked_write();
    test_dither();
    test_reset_armed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired exp finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/pwm_cmp_loader.md
# pwm_cmp_loader

Double-buffered compare-register loader feeding the PWM output-compare channels. A host-side writer deposits per-channel rising (cmpH) and falling (cmpL) compare words into shadow registers through a valid/ready port. A commit request transfers all shadows into the active compare outputs atomically, and only on the PWM timebase reload strobe, so no period ever sees a mixed old/new setting. Active outputs drive the `cmpH`/`cmpL` inputs of the downstream `pwmOC` instances.

## Interface
- `NCH`, 2, number of compare channels
- `WIDTH`, 18, integer compare width, matching the PWM timebase
- `FRAC`, 6, fractional compare bits carried by the write port
- `clk` input 1: single clock, shared with the PWM timebase.
- `rst` input 1: reset, synchronous, active-high.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write accepted when `wr_valid && wr_ready` at a clk edge.
- `wr_chan` input $clog2(NCH): target channel.
- `wr_sel` input 1: 0 = cmpH, 1 = cmpL.
- `wr_data` input WIDTH+FRAC: compare word. Upper WIDTH bits are the integer part; low FRAC bits are the fraction.
- `commit` input 1: single-cycle request to transfer shadows at the next boundary.
- `tb_zero` input 1: single-cycle strobe, high in the cycle the PWM timebase equals 0.
- `pending` output 1: a commit is armed and not yet transferred.
- `cmpH_o` output NCH×WIDTH: active rising-edge compares.
- `cmpL_o` output NCH×WIDTH: active falling-edge compares.

## Operation
- Shadow registers: per channel, `shH` (WIDTH bits) and `shL` (WIDTH+FRAC bits).
  - A cmpH write stores the upper WIDTH bits; its FRAC bits are discarded.
- `wr_ready` = !pending. Shadows are locked while a commit is armed.
- `wr_chan` ≥ NCH: the write is accepted and dropped; no register changes.
- State machine has two states:
  - IDLE: `commit` moves to ARMED and sets `pending`.
  - ARMED: `tb_zero` triggers the transfer, then returns to IDLE and clears `pending`. `commit` while ARMED is ignored.
- Transfer: for every channel, `cmpH_o` ← `shH` and `cmpL_o` ← integer part of `shL` (+ dither carry, see Configuration).
- Write and commit in the same cycle: the write lands in the shadow and is included in the armed transfer.
- `commit` and `tb_zero` in the same cycle while IDLE: the block arms; the transfer waits for the next `tb_zero`.
- `rst` mid-operation: `pending` cleared, state IDLE, shadows and active outputs zeroed, any armed commit lost.
- Reset values:
  - `cmpH_o` = 0, `cmpL_o` = 0, so PWM outputs are held low.
  - `pending` = 0, `wr_ready` = 1 from the first cycle after reset.
  - All shadows and accumulators = 0.

## Timing
- Write: shadow updated at the accepting edge; it never affects outputs directly.
- `pending` rises at the edge sampling `commit`.
- Transfer latency:
  - Outputs change at the edge that samples the qualifying `tb_zero`.
  - The new values are stable from the first cycle after the reload, before any compare match of the new period.
- `pending` falls at the same edge as the transfer; `wr_ready` rises with it.
- All outputs are registered; there is no combinational path from inputs to `cmpH_o`/`cmpL_o`.

## Configuration
- Macro: `PWM_CMP_DITHER_EN`.
- Defined:
  - Each channel keeps a FRAC-bit phase accumulator.
  - On every `tb_zero` (transfer or not), acc ← acc + frac(`shL`), using the shadow value active since the last transfer.
  - The carry-out adds 1 to that period's `cmpL_o`.
  - The addition saturates at 2^WIDTH−1 and never wraps.
  - Accumulators keep their value across transfers.
- Undefined: fraction bits are truncated, `cmpL_o` is exactly the integer part, and no accumulator registers exist.

## Structure
- Package `pwm_pkg`:
  - `PWM_WIDTH`, `PWM_FRAC`, `PWM_NCH` constants.
  - `cmp_sel_t` enum (`SEL_H`, `SEL_L`).
  - `ldr_state_t` enum (`IDLE`, `ARMED`).
- Sub-module `pwm_dither_acc`, one instance per channel:
  - Inputs: integer part, fraction, `tb_zero`.
  - Output: the dithered compare word.
  - Instantiated only under `PWM_CMP_DITHER_EN`.

## Test plan
- Reset released → `cmpH_o` = `cmpL_o` = 0, `pending` = 0, `wr_ready` = 1.
- Write ch1 H = 0x20000 and ch1 L = 0x0D709 (frac 0), then `commit`, then `tb_zero` 37 cycles later → outputs unchanged for 37 cycles; ch1 updates at the `tb_zero` edge; `pending` drops at the same edge.
- `commit` coincident with `tb_zero` → no transfer on that strobe; transfer on the next `tb_zero`.
- While `pending`, assert `wr_valid` with ch0 L = 0x12345 → `wr_ready` = 0, shadow unchanged; the write is accepted the cycle after the transfer.
- `PWM_CMP_DITHER_EN`, ch0 L integer 0x100 with frac 0x10 (1/4) → over 8 periods `cmpL_o` reads 0x101 exactly 2 times. Integer 0x3FFFF with frac 0x3F → `cmpL_o` stays 0x3FFFF (saturated).
- `rst` asserted while ARMED → `pending` = 0 and outputs = 0 next cycle; a subsequent `tb_zero` causes no transfer.
